// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame FSM with timeout and set-2 scancode decoder.
// Optional typematic-repeat suppression is enabled by defining PS2_TYPEMATIC_FILTER_EN.
`timescale 1ns/1ps

module ps2_keyboard_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic [7:0] RXDATA,
    output logic       EXTENDED,
    output logic       KEY_PRESSED,
    output logic       KEY_RELEASED,
    output logic       frame_err
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic                   filt_q, filt_d;
    logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
    logic                   fall_edge;
    logic                   clk_s, data_s;

    state_t                 state_q, state_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   parity_q, parity_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [7:0]             rx_byte_q, rx_byte_d;
    logic                   rx_byte_valid_q, rx_byte_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic [7:0]             rxdata_q, rxdata_d;
    logic                   extended_q, extended_d;
    logic                   key_pressed_q, key_pressed_d;
    logic                   key_released_q, key_released_d;
    logic                   break_pend_q, break_pend_d;
    logic                   ext_pend_q, ext_pend_d;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // NOTE: every always_comb assigns its defaults first, so no path can infer a latch.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        fall_edge   = 1'b0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FILT_MAX) begin
                filt_d    = clk_s;
                fall_edge = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        bit_cnt_d       = bit_cnt_q;
        parity_d        = parity_q;
        tmo_d           = '0;
        rx_byte_d       = rx_byte_q;
        rx_byte_valid_d = 1'b0;
        frame_err_d     = 1'b0;
        if (fall_edge) begin
            unique case (state_q)
                S_IDLE: begin
                    // A falling edge with data high is a glitch, not a start bit.
                    if (!data_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    parity_d = data_s;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    if (data_s && (^{shift_q, parity_q})) begin
                        rx_byte_d       = shift_q;
                        rx_byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d     = S_IDLE;
                frame_err_d = 1'b1;
                shift_d     = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] held_q, held_d;
    logic       held_valid_q, held_valid_d;
    logic       held_match;
    assign held_match = held_valid_q && (held_q == {ext_pend_q, rx_byte_q});
`endif

    always_comb begin
        rxdata_d       = rxdata_q;
        extended_d     = extended_q;
        key_pressed_d  = 1'b0;
        key_released_d = 1'b0;
        break_pend_d   = break_pend_q;
        ext_pend_d     = ext_pend_q;
`ifdef PS2_TYPEMATIC_FILTER_EN
        held_d         = held_q;
        held_valid_d   = held_valid_q;
`endif
        if (frame_err_q) begin
            break_pend_d = 1'b0;
            ext_pend_d   = 1'b0;
        end else if (rx_byte_valid_q) begin
            case (rx_byte_q)
                8'hE0: ext_pend_d   = 1'b1;
                8'hF0: break_pend_d = 1'b1;
                8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA,
                8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
                end
                default: begin
                    break_pend_d = 1'b0;
                    ext_pend_d   = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (break_pend_q) begin
                        key_released_d = 1'b1;
                        rxdata_d       = rx_byte_q;
                        extended_d     = ext_pend_q;
                        if (held_match) held_valid_d = 1'b0;
                    end else if (!held_match) begin
                        key_pressed_d = 1'b1;
                        rxdata_d      = rx_byte_q;
                        extended_d    = ext_pend_q;
                        held_d        = {ext_pend_q, rx_byte_q};
                        held_valid_d  = 1'b1;
                    end
`else
                    key_released_d = break_pend_q;
                    key_pressed_d  = !break_pend_q;
                    rxdata_d       = rx_byte_q;
                    extended_d     = ext_pend_q;
`endif
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q      <= '1;
            data_sync_q     <= '1;
            filt_q          <= 1'b1;
            filt_cnt_q      <= '0;
            state_q         <= S_IDLE;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            parity_q        <= 1'b0;
            tmo_q           <= '0;
            rx_byte_q       <= '0;
            rx_byte_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
            rxdata_q        <= '0;
            extended_q      <= 1'b0;
            key_pressed_q   <= 1'b0;
            key_released_q  <= 1'b0;
            break_pend_q    <= 1'b0;
            ext_pend_q      <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_q          <= '0;
            held_valid_q    <= 1'b0;
`endif
        end else begin
            clk_sync_q      <= clk_sync_d;
            data_sync_q     <= data_sync_d;
            filt_q          <= filt_d;
            filt_cnt_q      <= filt_cnt_d;
            state_q         <= state_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            parity_q        <= parity_d;
            tmo_q           <= tmo_d;
            rx_byte_q       <= rx_byte_d;
            rx_byte_valid_q <= rx_byte_valid_d;
            frame_err_q     <= frame_err_d;
            rxdata_q        <= rxdata_d;
            extended_q      <= extended_d;
            key_pressed_q   <= key_pressed_d;
            key_released_q  <= key_released_d;
            break_pend_q    <= break_pend_d;
            ext_pend_q      <= ext_pend_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_q          <= held_d;
            held_valid_q    <= held_valid_d;
`endif
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_byte_valid_q;
    assign RXDATA        = rxdata_q;
    assign EXTENDED      = extended_q;
    assign KEY_PRESSED   = key_pressed_q;
    assign KEY_RELEASED  = key_released_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed and random PS/2 frames against a scancode-rule reference model.
`timescale 1ns/1ps

module tb_ps2_keyboard_rx;

    localparam int SYNC = 2;
    localparam int FILT = 8;
    localparam int TMO  = 1000;
    localparam int H    = 25;           // PS/2 half-period in clk cycles
    localparam int VLAT = SYNC + FILT;  // posedges from pin fall of the stop bit to rx_byte_valid/frame_err

    logic       clk, reset_n, ps2_clk, ps2_data;
    logic [7:0] rx_byte, RXDATA;
    logic       rx_byte_valid, EXTENDED, KEY_PRESSED, KEY_RELEASED, frame_err;

    ps2_keyboard_rx #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .RXDATA(RXDATA), .EXTENDED(EXTENDED),
        .KEY_PRESSED(KEY_PRESSED), .KEY_RELEASED(KEY_RELEASED), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed traffic
    logic [7:0] got_bytes[$];
    logic [9:0] got_events[$];
    int got_errs = 0, n_press = 0, n_rel = 0, strobe_faults = 0;
    logic prev_v = 0, prev_e = 0, prev_p = 0, prev_r = 0;

    always @(negedge clk) begin
        if (rx_byte_valid) got_bytes.push_back(rx_byte);
        if (KEY_PRESSED || KEY_RELEASED) got_events.push_back({KEY_RELEASED, EXTENDED, RXDATA});
        if (frame_err) got_errs <= got_errs + 1;
        if (KEY_PRESSED) n_press <= n_press + 1;
        if (KEY_RELEASED) n_rel <= n_rel + 1;
        if ((KEY_PRESSED && KEY_RELEASED) || (rx_byte_valid && prev_v) || (frame_err && prev_e) ||
            (KEY_PRESSED && prev_p) || (KEY_RELEASED && prev_r))
            strobe_faults <= strobe_faults + 1;
        prev_v <= rx_byte_valid;
        prev_e <= frame_err;
        prev_p <= KEY_PRESSED;
        prev_r <= KEY_RELEASED;
    end

    // Reference model of the scancode rules
    logic       m_ext, m_brk, m_held_v, m_xbit;
    logic [8:0] m_held;
    logic [7:0] m_code;
    logic [7:0] exp_bytes[$];
    logic [9:0] exp_events[$];
    int         exp_errs = 0;

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held_v = 0; m_held = '0; m_code = '0; m_xbit = 0;
    endtask

    task automatic model_err();
        exp_errs++;
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit ev);
        ev = 0;
        exp_bytes.push_back(b);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (!(b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (m_brk) begin
                ev = 1;
                if (m_held_v && m_held == {m_ext, b}) m_held_v = 0;
            end else if (!(m_held_v && m_held == {m_ext, b})) begin
                ev = 1;
                m_held = {m_ext, b};
                m_held_v = 1;
            end
`else
            ev = 1;
`endif
            if (ev) begin
                exp_events.push_back({m_brk, m_ext, b});
                m_code = b;
                m_xbit = m_ext;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Drives nbits of a frame; after the last falling edge, watches for `budget` posedges.
    task automatic ps2_send(input logic [10:0] bits, input int nbits, input int budget,
                            output int lat_v, output int lat_k);
        lat_v = -1;
        lat_k = -1;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            if (i < nbits - 1) begin
                repeat (H) @(negedge clk);
                ps2_clk = 1'b1;
            end else begin
                for (int c = 1; c <= budget; c++) begin
                    @(posedge clk);
                    #1;
                    if (lat_v < 0 && (rx_byte_valid || frame_err)) lat_v = c;
                    if (lat_k < 0 && (KEY_PRESSED || KEY_RELEASED)) lat_k = c;
                    if (c == H) ps2_clk = 1'b1;
                end
            end
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic compare_all(input string tag);
        check({tag, "/n_bytes"}, got_bytes.size(), exp_bytes.size());
        while (got_bytes.size() > 0 && exp_bytes.size() > 0)
            check({tag, "/rx_byte"}, got_bytes.pop_front(), exp_bytes.pop_front());
        check({tag, "/n_events"}, got_events.size(), exp_events.size());
        while (got_events.size() > 0 && exp_events.size() > 0)
            check({tag, "/event"}, got_events.pop_front(), exp_events.pop_front());
        check({tag, "/frame_err_count"}, got_errs, exp_errs);
        check({tag, "/held_rxdata"}, {EXTENDED, RXDATA}, {m_xbit, m_code});
        got_bytes.delete();
        exp_bytes.delete();
        got_events.delete();
        exp_events.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
        bit ev;
        int lv, lk;
        if (!bad_par && !bad_stop) model_byte(b, ev);
        else begin
            ev = 0;
            model_err();
        end
        ps2_send(frame_bits(b, bad_par, bad_stop), 11, 2 * H, lv, lk);
        check({tag, "/lat_valid"}, lv, VLAT);
        check({tag, "/lat_key"}, lk, ev ? VLAT + 1 : -1);
        compare_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lv, lk, p0, r0;
        logic [7:0] b;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        reset_n = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check("reset_outputs", {rx_byte, rx_byte_valid, RXDATA, EXTENDED, KEY_PRESSED, KEY_RELEASED, frame_err}, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        send_byte(8'h1C, 0, 0, "make_1c");
        send_byte(8'hF0, 0, 0, "brk_f0");
        send_byte(8'h1C, 0, 0, "brk_1c");
        send_byte(8'hE0, 0, 0, "ext_e0");
        send_byte(8'h75, 0, 0, "ext_make_75");
        send_byte(8'hE0, 0, 0, "ext_e0b");
        send_byte(8'hF0, 0, 0, "ext_f0");
        send_byte(8'h75, 0, 0, "ext_brk_75");
        send_byte(8'h1C, 0, 0, "after_ext");
        send_byte(8'h16, 1, 0, "bad_parity");
        send_byte(8'h16, 0, 0, "good_16");
        send_byte(8'h2A, 0, 1, "bad_stop");
        send_byte(8'hAA, 0, 0, "ignored_aa");

        // Start bit plus 5 data bits, then the clock stays high until the timeout
        model_err();
        ps2_send(frame_bits(8'h33, 0, 0), 6, VLAT + TMO + 40, lv, lk);
        check("timeout/lat", lv, VLAT + TMO);
        check("timeout/no_key", lk, -1);
        compare_all("timeout");
        send_byte(8'h45, 0, 0, "after_timeout");

        // Falling edge with data high while idle is a glitch
        ps2_send(11'h7FF, 1, 4 * H, lv, lk);
        check("glitch/no_strobe", lv, -1);
        compare_all("glitch");

        p0 = n_press;
        r0 = n_rel;
        send_byte(8'h1C, 0, 0, "typ_1");
        send_byte(8'h1C, 0, 0, "typ_2");
        send_byte(8'h1C, 0, 0, "typ_3");
        send_byte(8'hF0, 0, 0, "typ_f0");
        send_byte(8'h1C, 0, 0, "typ_brk");
        send_byte(8'h1C, 0, 0, "typ_4");
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("typematic/presses", n_press - p0, 2);
`else
        check("typematic/presses", n_press - p0, 4);
`endif
        check("typematic/releases", n_rel - r0, 1);

        // Reset in the middle of a frame with a break pending
        send_byte(8'hF0, 0, 0, "pre_reset_f0");
        ps2_send(frame_bits(8'h5A, 0, 0), 4, H, lv, lk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_outputs", {rx_byte, rx_byte_valid, RXDATA, EXTENDED, KEY_PRESSED, KEY_RELEASED, frame_err}, 0);
        model_reset();
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h1C, 0, 0, "post_reset_make");

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 5))
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = ($urandom_range(0, 1) == 0) ? 8'h1C : 8'h75;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_byte(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0, "random");
        end

        check("strobe_width", strobe_faults, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and decodes set-2 scancode sequences into key events. Its RXDATA/KEY_PRESSED/KEY_RELEASED outputs drive the keyboard inputs of the OSD breakpoint editor: RXDATA holds the scancode, and each press or release produces a single-cycle strobe. It also exposes every raw byte and a frame-error strobe for debug. It runs entirely in the video/system `clk` domain.

## Interface
- SYNC_STAGES, 2: synchronizer flops on ps2_clk and ps2_data (minimum 2).
- FILTER_LEN, 8: number of consecutive equal synchronized ps2_clk samples required before the filtered clock level changes.
- TIMEOUT_CYCLES, 50000: number of `clk` cycles without a filtered falling edge, while a frame is in progress, before the frame is aborted.

- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous to `clk`.
- ps2_data  in  1  raw PS/2 data pin; asynchronous to `clk`.
- rx_byte  out  8  last correctly received byte, prefixes included.
- rx_byte_valid  out  1  1-cycle strobe when rx_byte is updated.
- RXDATA  out  8  scancode of the last key event; holds until the next event.
- EXTENDED  out  1  set when the last key event carried an E0 prefix; holds with RXDATA.
- KEY_PRESSED  out  1  1-cycle make strobe; RXDATA and EXTENDED are valid in the same cycle.
- KEY_RELEASED  out  1  1-cycle break strobe; RXDATA and EXTENDED are valid in the same cycle.
- frame_err  out  1  1-cycle strobe on a parity error, a bad stop bit, or a timeout.

## Operation
- Every output resets to 0.
- **Input conditioning:** both pins pass through SYNC_STAGES flops. The filtered clock level resets to 1. A falling edge is a filtered 1→0 transition. Data is sampled from synchronized ps2_data in the cycle the falling edge is detected.
- **Frame FSM:**
  - IDLE: on a falling edge, if data=0 go to DATA; if data=1, treat it as a glitch and stay in IDLE with no error.
  - DATA: shift in 8 bits, LSB first; a 3-bit counter wraps 7→0 and moves the FSM to PARITY.
  - PARITY: capture the bit and go to STOP.
  - STOP: sample the stop bit. The byte is good if the stop bit is 1 and the 8 data bits plus parity contain an odd number of ones. Good byte: update rx_byte and strobe rx_byte_valid. Bad byte: strobe frame_err and discard the byte. Either way, return to IDLE.
- **Timeout:** a counter clears on every falling edge and while in IDLE. When it reaches TIMEOUT_CYCLES in any state other than IDLE: go to IDLE, strobe frame_err, clear the shift register.
- **Decoder:** holds a break_pend flag and an ext_pend flag, both reset to 0. It acts on each rx_byte_valid:
  - E0: set ext_pend; no key event.
  - F0: set break_pend; no key event.
  - 00, AA, E1, EE, FA, FC, FD, FE, FF: consumed; no key event; pending flags unchanged.
  - Any other byte: load RXDATA from the byte and EXTENDED from ext_pend. Strobe KEY_RELEASED if break_pend is set, otherwise KEY_PRESSED. Then clear both pending flags.
- **frame_err** also clears both pending flags.
- **E1 (Pause):** the E1 byte itself is consumed. The bytes that follow it decode as ordinary codes; this is accepted behaviour.

## Timing
- rx_byte_valid or frame_err asserts 1 cycle after the filtered falling edge of the stop bit.
- KEY_PRESSED or KEY_RELEASED asserts 1 cycle after rx_byte_valid. RXDATA and EXTENDED change in that same cycle.
- Worst-case latency from the stop-bit falling edge at the pin to a key strobe is SYNC_STAGES + FILTER_LEN + 2 cycles.
- A timeout and a falling edge in the same cycle: the edge wins and the counter clears.
- Asserting reset_n mid-frame aborts the frame immediately and clears the FSM, pending flags, held key and all outputs.
- Strobes never last more than 1 cycle. KEY_PRESSED and KEY_RELEASED are never asserted together.

## Configuration
- PS2_TYPEMATIC_FILTER_EN defined:
  - The block tracks a held key {ext, code} with a valid bit, reset to 0.
  - A make matching the held key while valid is suppressed: no strobe, and RXDATA is unchanged.
  - Any other make strobes normally and replaces the held key.
  - A break matching the held key clears the valid bit. Every break strobes.
- PS2_TYPEMATIC_FILTER_EN undefined: every make strobes KEY_PRESSED, including typematic repeats.

## Test plan
- Frame 0x1C, valid parity → rx_byte=0x1C with rx_byte_valid; next cycle KEY_PRESSED=1, RXDATA=0x1C, EXTENDED=0.
- Bytes F0, 1C → one rx_byte_valid per byte; KEY_RELEASED only after 1C, with RXDATA=0x1C; no strobe on the F0 byte.
- Bytes E0 75, then E0 F0 75 → KEY_PRESSED with EXTENDED=1 and RXDATA=0x75; then KEY_RELEASED with EXTENDED=1; after the release, the next code decodes with EXTENDED=0.
- Frame 0x16 with even parity → frame_err=1, no rx_byte_valid, no key strobe. A following frame 0x16 with valid parity → KEY_PRESSED, RXDATA=0x16.
- Start bit plus 5 data bits, then ps2_clk held high → frame_err exactly TIMEOUT_CYCLES after the last edge. A following frame 0x45 → KEY_PRESSED, RXDATA=0x45.
- Bytes 1C 1C 1C F0 1C 1C:
  - With PS2_TYPEMATIC_FILTER_EN: pressed, released, pressed.
  - Without it: 3 pressed, 1 released, 1 pressed.
